// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer front end, the converter and their benches.
package thermo_pkg;

  localparam int unsigned THERMO_W = 7;

  typedef logic [THERMO_W-1:0] thermo_t;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } hs_state_e;

  // Legal codes are 0..01..1, so adding one leaves no bit in common with the code.
  function automatic logic is_thermo(thermo_t code);
    return ((code + THERMO_W'(1)) & code) == '0;
  endfunction

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/thermo_sampler_if.sv
// Delivery side of thermo_sampler: committed code, valid/ready pair and status pulses.
interface thermo_sampler_if #(
  parameter int unsigned WIDTH = thermo_pkg::THERMO_W
) ();

  logic [WIDTH-1:0] code_o;
  logic             valid_o;
  logic             ready_i;
  logic             bubble_o;
  logic             overrun_o;

  modport master (
    output code_o,
    output valid_o,
    output bubble_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  code_o,
    input  valid_o,
    input  bubble_o,
    input  overrun_o,
    output ready_i
  );

endinterface

// File: rtl/thermo_bubble_fix.sv
// Combinational bubble corrector. THERMO_BUBBLE_FIX_EN selects the 3-input majority
// filter; otherwise the code passes through unchanged.
module thermo_bubble_fix
  import thermo_pkg::*;
#(
  parameter int unsigned WIDTH = THERMO_W
) (
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] fixed_o
);

`ifdef THERMO_BUBBLE_FIX_EN
  // Pad below with 1 and above with 0 so the end bits see a legal neighbour.
  logic [WIDTH+1:0] ext;
  assign ext = {1'b0, raw_i, 1'b1};

  always_comb begin
    fixed_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fixed_o[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end
`else
  assign fixed_o = raw_i;
`endif

endmodule

// File: rtl/thermo_sampler.sv
// Comparator-bank front end: synchronise, strobe, debounce and hand each new code downstream.
// Build option THERMO_BUBBLE_FIX_EN enables bubble correction in thermo_bubble_fix.
module thermo_sampler
  import thermo_pkg::*;
#(
  parameter int unsigned WIDTH      = THERMO_W,
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] comp_raw,
  thermo_sampler_if.master bus
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(STABLE_CNT);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d, prev_cnt;
  logic [WIDTH-1:0] code_q, code_d;
  logic             bubble_q, bubble_d;
  logic             overrun_q, overrun_d;
  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] sample;
  logic             strobe, commit;

  thermo_bubble_fix #(
    .WIDTH (WIDTH)
  ) u_fix (
    .raw_i   (sync2_q),
    .fixed_o (sample)
  );

  assign strobe = en & (div_q == DivLast);

  always_comb begin
    sync1_d  = comp_raw;
    sync2_d  = sync1_q;
    div_d    = '0;
    if (en && (div_q != DivLast)) begin
      div_d = div_q + DivW'(1);
    end
    bubble_d = strobe & ~is_thermo(sync2_q);
  end

  // Debounce: a candidate must survive STABLE_CNT strobes; the commit fires only on the
  // strobe that reaches the threshold, and only for a code not already on the output.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    prev_cnt = '0;
    commit   = 1'b0;
    if (!en) begin
      cand_d = code_q;
      cnt_d  = CntSat;
    end else if (strobe) begin
      prev_cnt = (sample != cand_q) ? '0 : cnt_q;
      cnt_d    = (prev_cnt == CntSat) ? CntSat : prev_cnt + CntW'(1);
      cand_d   = sample;
      commit   = (cnt_d == CntSat) && (prev_cnt != CntSat) && (sample != code_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    overrun_d = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (commit) begin
          code_d  = sample;
          state_d = StFull;
        end
      end
      StFull: begin
        if (bus.ready_i) begin
          if (commit) begin
            code_d = sample;
          end else begin
            state_d = StEmpty;
          end
        end else if (commit) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= '0;
      cand_q    <= '0;
      cnt_q     <= CntSat;
      code_q    <= '0;
      bubble_q  <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= StEmpty;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      bubble_q  <= bubble_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign bus.code_o    = code_q;
  assign bus.valid_o   = (state_q == StFull);
  assign bus.bubble_o  = bubble_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_thermo_sampler.sv
// Self-checking bench for thermo_sampler: directed scenarios plus random traffic,
// all compared cycle by cycle against a run-length based reference model.
module tb_thermo_sampler;
  import thermo_pkg::*;

  localparam int W   = 7;
  localparam int DIV = 4;
  localparam int STB = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] comp_raw = '0;

  thermo_sampler_if #(.WIDTH(W)) bus ();

  thermo_sampler #(
    .WIDTH      (W),
    .SAMPLE_DIV (DIV),
    .STABLE_CNT (STB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .comp_raw (comp_raw),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (value after the most recent clock edge).
  logic [W-1:0] m_s1, m_s2, m_run_val, m_code;
  int           m_run_len, m_en_cycles;
  logic         m_valid, m_bubble, m_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [W-1:0] x);
    int c;
    c = $countones(x);
    return int'(x) == ((1 << c) - 1);
  endfunction

  function automatic logic [W-1:0] correct(input logic [W-1:0] x);
`ifdef THERMO_BUBBLE_FIX_EN
    logic [W-1:0] r;
    int lo, hi;
    for (int i = 0; i < W; i++) begin
      lo   = (i == 0) ? 1 : int'(x[(i == 0) ? 0 : i - 1]);
      hi   = (i == W - 1) ? 0 : int'(x[(i == W - 1) ? i : i + 1]);
      r[i] = (lo + int'(x[i]) + hi) >= 2;
    end
    return r;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = STB; m_en_cycles = 0;
    m_code = '0; m_valid = 1'b0; m_bubble = 1'b0; m_overrun = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [W-1:0] samp;
    logic strobe, commit;
    strobe   = en && ((m_en_cycles % DIV) == DIV - 1);
    samp     = correct(m_s2);
    m_bubble = strobe && !legal(m_s2);
    commit   = 1'b0;
    if (!en) begin
      m_run_val = m_code;
      m_run_len = STB;
    end else if (strobe) begin
      if (samp == m_run_val) m_run_len++;
      else begin
        m_run_val = samp;
        m_run_len = 1;
      end
      commit = (m_run_len == STB) && (samp != m_code);
    end
    m_overrun = 1'b0;
    if (m_valid && !bus.ready_i) m_overrun = commit;
    else if (commit) begin
      m_code  = samp;
      m_valid = 1'b1;
    end else if (m_valid) m_valid = 1'b0;
    m_en_cycles = en ? m_en_cycles + 1 : 0;
    m_s2 = m_s1;
    m_s1 = comp_raw;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("code", 32'(bus.code_o), 32'(m_code));
    check("valid", 32'(bus.valid_o), 32'(m_valid));
    check("bubble", 32'(bus.bubble_o), 32'(m_bubble));
    check("overrun", 32'(bus.overrun_o), 32'(m_overrun));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"}, 32'(bus.code_o), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_bubble"}, 32'(bus.bubble_o), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun_o), 32'd0);
  endtask

  int lat, got, cnt, hold, en_off, c;

  initial begin
    bus.ready_i = 1'b1;
    en = 1'b1;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle input: nothing is ever delivered.
    run(20);
    check("idle_code", 32'(bus.code_o), 32'd0);

    // First real code reaches valid_o within the latency window.
    comp_raw = 7'b0000111;
    got = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (got == 0 && bus.valid_o === 1'b1) begin
        got = 1;
        lat = i;
      end
    end
    check("latency_ok", 32'(got == 1 && lat <= 11), 32'd1);

    // Bubbled code: one bubble pulse per strobe.
    comp_raw = 7'b0001011;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (bus.bubble_o === 1'b1) cnt++;
    end
    check("bubble_pulses", 32'(cnt), 32'd4);
`ifdef THERMO_BUBBLE_FIX_EN
    check("bubble_code", 32'(bus.code_o), 32'h07);
`else
    check("bubble_code", 32'(bus.code_o), 32'h0B);
`endif

    // Glitch seen by exactly one strobe is not committed.
    comp_raw = 7'b0000111;
    run(16);
    comp_raw = 7'b0011111;
    run(DIV);
    comp_raw = 7'b0000111;
    run(16);
    check("glitch_code", 32'(bus.code_o), 32'h07);

    // Back-pressure: the second commit is dropped with one overrun pulse.
    bus.ready_i = 1'b0;
    comp_raw = 7'b0001111;
    run(14);
    comp_raw = 7'b0111111;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (bus.overrun_o === 1'b1) cnt++;
    end
    check("overrun_once", 32'(cnt), 32'd1);
    check("held_code", 32'(bus.code_o), 32'h0F);
    check("held_valid", 32'(bus.valid_o), 32'd1);
    bus.ready_i = 1'b1;
    cycle();
    check("delivered", 32'(bus.valid_o), 32'd0);

    // Asynchronous reset while a code is pending.
    bus.ready_i = 1'b0;
    comp_raw = 7'b0000011;
    run(14);
    check("pending_valid", 32'(bus.valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    comp_raw = '0;
    bus.ready_i = 1'b1;
    rst_n = 1'b1;
    run(20);

    // Random traffic: legal and illegal codes, random hold times, back-pressure and en drops.
    hold = 0; en_off = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        if ($urandom_range(9) < 7) begin
          c = int'($urandom_range(W));
          comp_raw = W'((1 << c) - 1);
        end else begin
          comp_raw = W'($urandom);
        end
        hold = int'($urandom_range(12, 1));
      end
      hold--;
      bus.ready_i = ($urandom_range(3) != 0);
      if (en_off > 0) begin
        en = 1'b0;
        en_off--;
      end else if ($urandom_range(99) < 3) begin
        en = 1'b0;
        en_off = int'($urandom_range(5));
      end else begin
        en = 1'b1;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
